mem_stage_sram_param: RTL and testbench

Parametrised memory stage for the pipelined ARM core, placed between the EXE/MEM register and the MEM/WB register. It turns one word-wide load or store into a sequence of narrower external SRAM accesses with a fixed number of wait cycles per access. It stalls the pipeline through `ready` until the access completes and gates write-back while stalled. Compared with the fixed 32/16-bit stage, it adds configurable word width, SRAM width, base address and wait states, plus an out-of-range address error.

---
 rtl/mem_stage_sram_param_if.sv | 24 ++
 rtl/mem_stage_sram_param.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_sram_param.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_param_if.sv
// Pipeline-side bundle of the memory stage: request from EXE/MEM, response to MEM/WB.
interface mem_stage_sram_param_if #(
    parameter int WORD_W = 32
) ();
    logic              memRead;
    logic              memWrite;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
    logic              writeBackEnIn;
    logic [WORD_W-1:0] memResult;
    logic              writeBackEn;
    logic              ready;
    logic              addrErr;

    modport master (
        output memRead, memWrite, address, data, writeBackEnIn,
        input  memResult, writeBackEn, ready, addrErr
    );

    modport slave (
        input  memRead, memWrite, address, data, writeBackEnIn,
        output memResult, writeBackEn, ready, addrErr
    );
endinterface

// File: rtl/mem_stage_sram_param.sv
// Memory stage that splits one pipeline word into BEATS narrow SRAM accesses,
// each lasting WAIT_CYCLES cycles, and stalls the pipeline via ready meanwhile.
module mem_stage_sram_param #(
    parameter int          WORD_W      = 32,
    parameter int          SRAM_DW     = 16,
    parameter int          SRAM_AW     = 18,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stage_sram_param_if.slave pipe,
    inout  wire  [SRAM_DW-1:0]   sramData,
    output logic [SRAM_AW-1:0]   sramAddress,
    output logic [4:0]           sramCtrl
);
    localparam int BEATS      = WORD_W / SRAM_DW;
    localparam int BYTE_SHIFT = $clog2(WORD_W / 8);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_W     = $clog2(WAIT_CYCLES);
    localparam int EXT_W      = WORD_W + BEAT_W + 1;

    localparam logic [WORD_W-1:0] BASE       = WORD_W'(BASE_ADDR);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [EXT_W-1:0]  SRAM_WORDS = EXT_W'(1) << SRAM_AW;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

    stateT             stateReg, stateNext;
    logic [BEAT_W-1:0] beatReg, beatNext;
    logic [WAIT_W-1:0] waitReg, waitNext;
    logic              opWriteReg, opWriteNext;
    logic              errReg, errNext;
    logic [WORD_W-1:0] rdBufReg, rdBufNext;
    logic [WORD_W-1:0] memResultReg, memResultNext;

    logic               request;
    logic               lastCycle;
    logic               lastBeat;
    logic               outOfRange;
    logic               readyComb;
    logic               sramDriveEn;
    logic [WORD_W-1:0]  offset;
    logic [WORD_W-1:0]  wordIdx;
    logic [EXT_W-1:0]   firstBeat;
    logic [WORD_W-1:0]  assembled;
    logic [SRAM_DW-1:0] wrSlice [BEATS];

    assign request   = pipe.memRead | pipe.memWrite;
    assign lastCycle = (waitReg == LAST_WAIT);
    assign lastBeat  = (beatReg == LAST_BEAT);

    // Address decode; widened so the range check cannot wrap for large indices.
    assign offset      = pipe.address - BASE;
    assign wordIdx     = offset >> BYTE_SHIFT;
    assign firstBeat   = EXT_W'(wordIdx) * EXT_W'(BEATS);
    assign outOfRange  = (pipe.address < BASE) ||
                         ((firstBeat + EXT_W'(BEATS - 1)) >= SRAM_WORDS);
    assign sramAddress = SRAM_AW'(firstBeat + EXT_W'(beatReg));

    // Beat slicing: store slices and the load word with the current beat patched in.
    for (genvar gi = 0; gi < BEATS; gi++) begin : gBeat
        assign wrSlice[gi] = pipe.data[gi*SRAM_DW +: SRAM_DW];
        assign assembled[gi*SRAM_DW +: SRAM_DW] =
            (beatReg == BEAT_W'(gi)) ? sramData : rdBufReg[gi*SRAM_DW +: SRAM_DW];
    end

    assign sramData = sramDriveEn ? wrSlice[beatReg] : {SRAM_DW{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg     <= IDLE;
            beatReg      <= '0;
            waitReg      <= '0;
            opWriteReg   <= 1'b0;
            errReg       <= 1'b0;
            rdBufReg     <= '0;
            memResultReg <= '0;
        end else begin
            stateReg     <= stateNext;
            beatReg      <= beatNext;
            waitReg      <= waitNext;
            opWriteReg   <= opWriteNext;
            errReg       <= errNext;
            rdBufReg     <= rdBufNext;
            memResultReg <= memResultNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        beatNext      = beatReg;
        waitNext      = waitReg;
        opWriteNext   = opWriteReg;
        errNext       = errReg;
        rdBufNext     = rdBufReg;
        memResultNext = memResultReg;
        readyComb     = 1'b1;
        sramCtrl      = 5'b11111;
        sramDriveEn   = 1'b0;

        case (stateReg)
            IDLE: begin
                if (request) begin
                    readyComb   = 1'b0;
                    beatNext    = '0;
                    waitNext    = '0;
                    opWriteNext = pipe.memWrite;
                    errNext     = outOfRange;
                    if (outOfRange) begin
                        stateNext = DONE;
                        if (!pipe.memWrite) begin
                            memResultNext = '0;
                        end
                    end else begin
                        stateNext = ACCESS;
                    end
                end
            end

            ACCESS: begin
                readyComb   = 1'b0;
                sramCtrl[3] = 1'b0;
                sramCtrl[2] = 1'b0;
                sramCtrl[1] = 1'b0;
                if (opWriteReg) begin
                    // we_n rises on the last cycle so data is held past the write strobe.
                    sramCtrl[4] = lastCycle;
                    sramCtrl[0] = 1'b1;
                    sramDriveEn = 1'b1;
                end else begin
                    sramCtrl[4] = 1'b1;
                    sramCtrl[0] = 1'b0;
                end

                if (lastCycle) begin
                    waitNext = '0;
                    if (!opWriteReg) begin
                        rdBufNext = assembled;
                    end
                    if (lastBeat) begin
                        stateNext = DONE;
                        if (!opWriteReg) begin
                            memResultNext = assembled;
                        end
                    end else begin
                        beatNext = beatReg + 1'b1;
                    end
                end else begin
                    waitNext = waitReg + 1'b1;
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign pipe.ready       = readyComb;
    assign pipe.writeBackEn = readyComb & pipe.writeBackEnIn;
    assign pipe.memResult   = memResultReg;
    assign pipe.addrErr     = (stateReg == DONE) & errReg;
endmodule

// File: tb/tb_mem_stage_sram_param.sv
// Directed bench: default 32/16 stage plus a 32/8, two-wait-cycle instance.
module tb_mem_stage_sram_param;
    logic clk;
    logic rst;
    int   checkCount = 0;
    int   errCount   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_stage_sram_param_if #(.WORD_W(32)) pipe ();
    mem_stage_sram_param_if #(.WORD_W(32)) pipe8 ();

    wire  [15:0] sramData;
    logic [17:0] sramAddress;
    logic [4:0]  sramCtrl;
    wire  [7:0]  sramData8;
    logic [17:0] sramAddress8;
    logic [4:0]  sramCtrl8;

    mem_stage_sram_param dut (
        .clk         (clk),
        .rst         (rst),
        .pipe        (pipe),
        .sramData    (sramData),
        .sramAddress (sramAddress),
        .sramCtrl    (sramCtrl)
    );

    mem_stage_sram_param #(.SRAM_DW(8), .WAIT_CYCLES(2)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .pipe        (pipe8),
        .sramData    (sramData8),
        .sramAddress (sramAddress8),
        .sramCtrl    (sramCtrl8)
    );

    // SRAM models: drive on read (we_n=1, ce_n=0, oe_n=0), capture while we_n=0.
    logic [15:0] mem16 [64];
    logic [7:0]  mem8  [64];
    wire tbDrive  = sramCtrl[4]  & ~sramCtrl[1]  & ~sramCtrl[0];
    wire tbDrive8 = sramCtrl8[4] & ~sramCtrl8[1] & ~sramCtrl8[0];
    assign sramData  = tbDrive  ? mem16[sramAddress[5:0]] : 16'bz;
    assign sramData8 = tbDrive8 ? mem8[sramAddress8[5:0]] : 8'bz;

    always @(posedge clk) begin
        if (!sramCtrl[4] && !sramCtrl[1]) mem16[sramAddress[5:0]] <= sramData;
        if (!sramCtrl8[4] && !sramCtrl8[1]) mem8[sramAddress8[5:0]] <= sramData8;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts stalled cycles from the current one until ready rises (bounded).
    task automatic waitReady(output int stall, output int errs);
        stall = 0;
        errs  = 0;
        while (pipe.ready !== 1'b1 && stall < 40) begin
            stall++;
            @(negedge clk);
            #1;
            if (pipe.addrErr) errs++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stall;
        int errs;
        int weLow;
        int beat;
        int cyc;

        rst = 1'b0;
        pipe.memRead = 0; pipe.memWrite = 0; pipe.address = 0; pipe.data = 0; pipe.writeBackEnIn = 0;
        pipe8.memRead = 0; pipe8.memWrite = 0; pipe8.address = 0; pipe8.data = 0; pipe8.writeBackEnIn = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset asserted in the middle of a write beat
        @(negedge clk);
        pipe.memWrite = 1; pipe.address = 1032; pipe.data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkVal("rst_midbeat_drive", 32'(dut.sramDriveEn), 1);
        rst = 1'b0;
        #1;
        checkVal("rst_ctrl", 32'(sramCtrl), 32'h1F);
        checkVal("rst_bus_z", 32'(dut.sramDriveEn), 0);
        checkVal("rst_memresult", pipe.memResult, 0);
        checkVal("rst_state_idle", 32'(dut.stateReg), 0);
        checkVal("rst_addrerr", 32'(pipe.addrErr), 0);
        @(negedge clk);
        pipe.memWrite = 0;
        rst = 1'b1;
        #1;
        checkVal("rst_ready", 32'(pipe.ready), 1);
        $display("reset mid-beat: ctrl=%b memResult=%h", sramCtrl, pipe.memResult);

        // Store 0xDEADBEEF at 1032 -> SRAM words 4 (BEEF) and 5 (DEAD)
        @(negedge clk);
        pipe.memWrite = 1; pipe.address = 1032; pipe.data = 32'hDEADBEEF; pipe.writeBackEnIn = 1;
        #1;
        checkVal("st_ready_c0", 32'(pipe.ready), 0);
        checkVal("st_wb_c0", 32'(pipe.writeBackEn), 0);
        stall = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            beat = i / 3;
            cyc  = i % 3;
            checkVal($sformatf("st_addr_%0d", i), 32'(sramAddress), 32'(4 + beat));
            checkVal($sformatf("st_data_%0d", i), 32'(sramData), (beat == 0) ? 32'hBEEF : 32'hDEAD);
            checkVal($sformatf("st_ctrl_%0d", i), 32'(sramCtrl), (cyc == 2) ? 32'h11 : 32'h01);
            if (!pipe.ready) stall++;
        end
        @(negedge clk);
        #1;
        checkVal("st_ready_done", 32'(pipe.ready), 1);
        checkVal("st_stall", 32'(stall), 7);
        checkVal("st_wb_done", 32'(pipe.writeBackEn), 1);
        pipe.memWrite = 0;
        @(negedge clk);
        #1;
        checkVal("st_idle_ctrl", 32'(sramCtrl), 32'h1F);
        checkVal("st_idle_bus_z", 32'(dut.sramDriveEn), 0);
        checkVal("st_idle_ready", 32'(pipe.ready), 1);
        checkVal("st_mem4", 32'(mem16[4]), 32'hBEEF);
        checkVal("st_mem5", 32'(mem16[5]), 32'hDEAD);
        $display("store addr=1032 data=deadbeef stall=%0d", stall);

        // Load back from 1032
        @(negedge clk);
        pipe.memRead = 1; pipe.address = 1032;
        #1;
        checkVal("ld_ready_c0", 32'(pipe.ready), 0);
        checkVal("ld_wb_c0", 32'(pipe.writeBackEn), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checkVal($sformatf("ld_ctrl_%0d", i), 32'(sramCtrl), 32'h10);
            checkVal($sformatf("ld_wb_%0d", i), 32'(pipe.writeBackEn), 0);
        end
        @(negedge clk);
        #1;
        checkVal("ld_ready_done", 32'(pipe.ready), 1);
        checkVal("ld_result_done", pipe.memResult, 32'hDEADBEEF);
        checkVal("ld_wb_done", 32'(pipe.writeBackEn), 1);
        pipe.memRead = 0;
        @(negedge clk);
        #1;
        checkVal("ld_result_hold", pipe.memResult, 32'hDEADBEEF);
        $display("load addr=1032 result=%h", pipe.memResult);

        // Load below BASE_ADDR
        @(negedge clk);
        pipe.memRead = 1; pipe.address = 1000;
        #1;
        checkVal("errlo_ready_c0", 32'(pipe.ready), 0);
        @(negedge clk);
        #1;
        checkVal("errlo_ready_c1", 32'(pipe.ready), 1);
        checkVal("errlo_addrerr", 32'(pipe.addrErr), 1);
        checkVal("errlo_result", pipe.memResult, 0);
        checkVal("errlo_ctrl", 32'(sramCtrl), 32'h1F);
        pipe.memRead = 0;
        @(negedge clk);
        #1;
        checkVal("errlo_addrerr_end", 32'(pipe.addrErr), 0);
        $display("load addr=1000 addrErr seen, result=%h", pipe.memResult);

        // Store just past the top of the SRAM (first out-of-range word)
        @(negedge clk);
        pipe.memWrite = 1; pipe.address = 525312; pipe.data = 32'hFFFFFFFF;
        #1;
        checkVal("errhi_ready_c0", 32'(pipe.ready), 0);
        @(negedge clk);
        #1;
        checkVal("errhi_addrerr", 32'(pipe.addrErr), 1);
        checkVal("errhi_bus_z", 32'(dut.sramDriveEn), 0);
        checkVal("errhi_ctrl", 32'(sramCtrl), 32'h1F);
        pipe.memWrite = 0;
        @(negedge clk);
        $display("store addr=525312 dropped with addrErr");

        // Store to the last in-range word
        pipe.memWrite = 1; pipe.address = 525308; pipe.data = 32'h0;
        #1;
        waitReady(stall, errs);
        checkVal("top_stall", 32'(stall), 7);
        checkVal("top_noerr", 32'(errs), 0);
        pipe.memWrite = 0;
        @(negedge clk);
        $display("store addr=525308 stall=%0d", stall);

        // Read+write together, then an immediate second load
        pipe.memRead = 1; pipe.memWrite = 1; pipe.address = 1036; pipe.data = 32'hCAFEF00D;
        #1;
        checkVal("pri_ready_c0", 32'(pipe.ready), 0);
        @(negedge clk);
        #1;
        checkVal("pri_is_write", 32'(sramCtrl), 32'h01);
        waitReady(stall, errs);
        checkVal("pri_stall", 32'(stall), 6);
        checkVal("pri_result_kept", pipe.memResult, 0);
        pipe.memWrite = 0;
        #1;
        checkVal("b2b_done_ready", 32'(pipe.ready), 1);
        @(negedge clk);
        #1;
        checkVal("b2b_idle_ready", 32'(pipe.ready), 0);
        checkVal("b2b_idle_ctrl", 32'(sramCtrl), 32'h1F);
        checkVal("b2b_idle_bus_z", 32'(dut.sramDriveEn), 0);
        @(negedge clk);
        #1;
        checkVal("b2b_read_ctrl", 32'(sramCtrl), 32'h10);
        waitReady(stall, errs);
        checkVal("b2b_stall", 32'(stall), 6);
        checkVal("b2b_result", pipe.memResult, 32'hCAFEF00D);
        checkVal("pri_mem6", 32'(mem16[6]), 32'hF00D);
        checkVal("pri_mem7", 32'(mem16[7]), 32'hCAFE);
        pipe.memRead = 0;
        $display("priority write + load addr=1036 result=%h", pipe.memResult);

        // Byte-wide SRAM, two wait cycles per beat
        @(negedge clk);
        pipe8.memWrite = 1; pipe8.address = 1024; pipe8.data = 32'h11223344;
        #1;
        stall = 0;
        weLow = 0;
        for (int i = 0; i < 40 && pipe8.ready !== 1'b1; i++) begin
            stall++;
            @(negedge clk);
            #1;
            if (!sramCtrl8[4]) weLow++;
        end
        checkVal("sw_stall", 32'(stall), 9);
        checkVal("sw_we_low", 32'(weLow), 4);
        checkVal("sw_mem0", 32'(mem8[0]), 32'h44);
        checkVal("sw_mem1", 32'(mem8[1]), 32'h33);
        checkVal("sw_mem2", 32'(mem8[2]), 32'h22);
        checkVal("sw_mem3", 32'(mem8[3]), 32'h11);
        pipe8.memWrite = 0;
        @(negedge clk);
        $display("sweep store addr=1024 data=11223344 stall=%0d", stall);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
